scan_ctrl: RTL and testbench
============================

# scan_ctrl

Scan-test sequencer that drives a chain built from the library's scan flops (SDFF/SDFFR/SDFFS) and clock gate (ICG). It serially loads stimulus words through SI with SE high, pulses one capture cycle with SE low, and unloads each response through SO while the next pattern loads. Each response is compared against an expected word, and the block reports a sticky pass/fail and a per-pattern mismatch count. It sits between a test-pattern source (BIST ROM or JTAG data register) and one scan chain.

## Interface
- CHAIN_LEN, 32: number of flops in the chain; also the width of pattern and expected words; must be at least 2.
- CK  in  1  clock. Also the source clock of the chain's ICG.
- RN  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle pulse that begins a session. Ignored while BUSY.
- PAT_VALID  in  1  pattern word available.
- PAT_READY  out  1  controller accepts a pattern on the CK edge where PAT_VALID&PAT_READY.
- PAT_DATA  in  CHAIN_LEN  stimulus word. Bit i is shifted on shift cycle i.
- EXP_DATA  in  CHAIN_LEN  expected capture response for this pattern. Bit i is compared on unload cycle i.
- PAT_LAST  in  1  qualifies the final pattern of the session.
- CKEN  out  1  EN input of the chain ICG; the chain is clocked only when CKEN=1.
- SE  out  1  chain scan enable.
- SI  out  1  chain serial input.
- SO  in  1  chain serial output, i.e. Q of the last flop.
- BUSY  out  1  session in progress.
- DONE  out  1  one-cycle pulse when the session ends.
- FAIL  out  1  sticky; set by any mismatch, cleared by START.
- FAIL_CNT  out  8  number of mismatching patterns, saturating at 255, cleared by START.

## Operation
- Reset value of every output is 0: PAT_READY, CKEN, SE, SI, BUSY, DONE, FAIL, FAIL_CNT.
- States and transitions:
  - IDLE: START → FETCH, BUSY=1, FAIL and FAIL_CNT cleared, cmp_en=0.
  - FETCH: PAT_READY=1, CKEN=0. On handshake, latch PAT_DATA, EXP_DATA and PAT_LAST, then go to SHIFT. While PAT_VALID=0 the block stalls indefinitely; the chain is held because CKEN=0.
  - SHIFT: CHAIN_LEN cycles with CKEN=1, SE=1, SI=pat[cnt], cnt=0..CHAIN_LEN-1. If cmp_en, compare SO against exp_prev[cnt] each cycle. Then go to CAPTURE.
  - CAPTURE: one cycle with CKEN=1, SE=0. Copy the latched expected word to exp_prev and set cmp_en=1. If the latched PAT_LAST=1 go to UNLOAD, else go to FETCH.
  - UNLOAD: CHAIN_LEN cycles with CKEN=1, SE=1, SI=0, comparing as in SHIFT. Then go to DONE_S.
  - DONE_S: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Comparison is skipped for the first pattern's shift because chain contents are undefined.
- A pattern mismatches if any of its CHAIN_LEN compared bits differs. At the end of that pattern's unload window, set FAIL and increment FAIL_CNT, saturating at 255.
- Reset asserted mid-session aborts immediately: all state and outputs return to reset values and the chain is left in an undefined state. The next session needs a new START.
- START during BUSY has no effect.

## Timing
- CKEN, SE and SI are registered outputs. Values driven in cycle n take effect at the chain on the CK rising edge that ends cycle n; the ICG latches EN while CK is low.
- SO is sampled on the same edge on which the chain shifts.
- Per-pattern cost: 1 FETCH cycle (with PAT_VALID held high), CHAIN_LEN SHIFT cycles and 1 CAPTURE cycle.
- Session of P patterns with no stalls: 1 + P·(CHAIN_LEN+2) + CHAIN_LEN + 1 cycles from START to DONE.
- FAIL and FAIL_CNT reflect a pattern's result on the cycle after its last compare, so both are valid when DONE pulses.

## Structure
- Package scan_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, CAPTURE, UNLOAD, DONE_S);
  - the counter width constant CNT_W = clog2(CHAIN_LEN);
  - the FAIL_CNT width (8) and saturation constant.
- Sub-module scan_ctrl_cmp holds the compare and fail accumulator. Inputs: cmp_en, bit strobe, last-bit strobe, SO, exp bit. Outputs: FAIL, FAIL_CNT.
- Top level holds the FSM, the shift counter, and the pattern and expected registers.

## Test plan
Bench: CHAIN_LEN=8; chain built from 8 SDFFR cells with functional D=~Q, clocked by ICG(CK, CKEN).
- One pattern, PAT_DATA=8'hA5, EXP_DATA=8'h5A, PAT_LAST=1 → DONE 20 cycles after START, FAIL=0, FAIL_CNT=0.
- Three patterns with words 8'h00, 8'hFF, 8'h3C and matching expected words, except the second has EXP_DATA=8'h01 → FAIL=1, FAIL_CNT=1 at DONE, total 40 cycles.
- PAT_VALID withheld for 5 cycles between patterns → CKEN=0 throughout the stall, chain unchanged, result identical to the no-stall run plus 5 cycles.
- RN pulsed low during the SHIFT of pattern 2 → all outputs 0 immediately; a new session then passes with FAIL=0.
- START pulsed while BUSY → no restart, cycle count unchanged. 300 failing patterns → FAIL_CNT saturates at 255.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan-test sequencer.
// Covers FSM state encoding, counter sizing and fail-counter saturation.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE_S
  } state_t;

  localparam int CHAIN_LEN_DEF = 32;

  function automatic int cnt_w(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  localparam int CNT_W = cnt_w(CHAIN_LEN_DEF);

  localparam int FCNT_W = 8;
  localparam logic [FCNT_W-1:0] FCNT_MAX = 8'd255;

endpackage

// File: rtl/scan_ctrl_if.sv
// Bundle between the pattern source / scan chain side (master) and the sequencer (slave).
interface scan_ctrl_if #(parameter int CHAIN_LEN = 32);
  import scan_ctrl_pkg::*;

  logic                 start;
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_data;
  logic [CHAIN_LEN-1:0] exp_data;
  logic                 pat_last;
  logic                 cken;
  logic                 se;
  logic                 si;
  logic                 so;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [FCNT_W-1:0]    fail_cnt;

  modport master (
    output start, pat_valid, pat_data, exp_data, pat_last, so,
    input  pat_ready, cken, se, si, busy, done, fail, fail_cnt
  );

  modport slave (
    input  start, pat_valid, pat_data, exp_data, pat_last, so,
    output pat_ready, cken, se, si, busy, done, fail, fail_cnt
  );

endinterface

// File: rtl/scan_ctrl_cmp.sv
// Response comparator: accumulates per-bit mismatches over one unload window and
// folds them into a sticky fail flag and a saturating failing-pattern count.
module scan_ctrl_cmp
  import scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cmp_en,
  input  logic              bit_stb,
  input  logic              last_stb,
  input  logic              so,
  input  logic              exp_bit,
  output logic              fail,
  output logic [FCNT_W-1:0] fail_cnt
);

  logic acc;
  logic miss;

  assign miss = acc | (so ^ exp_bit);

  // The window result is committed on its last bit so it is visible the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else if (clr) begin
      acc      <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else if (cmp_en && bit_stb) begin
      if (last_stb) begin
        acc <= 1'b0;
        if (miss) begin
          fail <= 1'b1;
          if (fail_cnt != FCNT_MAX) begin
            fail_cnt <= fail_cnt + 1'b1;
          end
        end
      end else begin
        acc <= miss;
      end
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Scan-test sequencer: loads each pattern through SI, pulses one capture cycle,
// and unloads the previous response through SO while the next pattern shifts in.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_ctrl_if.slave bus
);

  localparam int CW = (CHAIN_LEN == CHAIN_LEN_DEF) ? CNT_W : cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] exp_prev;
  logic                 last_q;
  logic                 cmp_en;
  logic                 pat_ready;
  logic                 cken;
  logic                 se;
  logic                 si;
  logic                 busy;
  logic                 done;
  logic                 accept;
  logic                 bit_stb;
  logic                 last_stb;
  logic                 exp_bit;
  logic                 fail;
  logic [FCNT_W-1:0]    fail_cnt;

  assign cnt_nxt  = cnt + CW'(1);
  assign accept   = (state == IDLE) && bus.start;
  assign bit_stb  = (state == SHIFT) || (state == UNLOAD);
  assign last_stb = (cnt == LAST_IDX);
  assign exp_bit  = exp_prev[cnt];

  // Chain controls are registered, so each is loaded on the edge entering the cycle it governs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      exp_prev  <= '0;
      last_q    <= 1'b0;
      cmp_en    <= 1'b0;
      pat_ready <= 1'b0;
      cken      <= 1'b0;
      se        <= 1'b0;
      si        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            cmp_en    <= 1'b0;
            pat_ready <= 1'b1;
            cken      <= 1'b0;
            se        <= 1'b0;
            si        <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.pat_valid && pat_ready) begin
            pat_q     <= bus.pat_data;
            exp_q     <= bus.exp_data;
            last_q    <= bus.pat_last;
            pat_ready <= 1'b0;
            cnt       <= '0;
            cken      <= 1'b1;
            se        <= 1'b1;
            si        <= bus.pat_data[0];
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST_IDX) begin
            cnt   <= '0;
            se    <= 1'b0;
            si    <= 1'b0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt_nxt;
            si  <= pat_q[cnt_nxt];
          end
        end
        CAPTURE: begin
          exp_prev <= exp_q;
          cmp_en   <= 1'b1;
          if (last_q) begin
            cnt   <= '0;
            se    <= 1'b1;
            si    <= 1'b0;
            state <= UNLOAD;
          end else begin
            cken      <= 1'b0;
            se        <= 1'b0;
            pat_ready <= 1'b1;
            state     <= FETCH;
          end
        end
        UNLOAD: begin
          if (cnt == LAST_IDX) begin
            cnt   <= '0;
            cken  <= 1'b0;
            se    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_S;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE_S: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  scan_ctrl_cmp u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .cmp_en   (cmp_en),
    .bit_stb  (bit_stb),
    .last_stb (last_stb),
    .so       (bus.so),
    .exp_bit  (exp_bit),
    .fail     (fail),
    .fail_cnt (fail_cnt)
  );

  assign bus.pat_ready = pat_ready;
  assign bus.cken      = cken;
  assign bus.se        = se;
  assign bus.si        = si;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.fail      = fail;
  assign bus.fail_cnt  = fail_cnt;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl with an 8-flop inverting scan chain behind a clock gate;
// expected results come from the capture rule (response = ~stimulus) and session timing.
module tb_scan_ctrl;

  localparam int L = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  scan_ctrl_if #(.CHAIN_LEN(L)) sif ();

  scan_ctrl #(.CHAIN_LEN(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  // Clock gate latches its enable while the clock is low; the flops then
  // advance only on edges where that latched enable is high.
  logic         enLat;
  logic [L-1:0] chain;
  logic [L-1:0] chainSeed = 8'hC6;
  logic         primed    = 1'b0;

  always @(clk or sif.cken) begin
    if (!clk) enLat <= sif.cken;
  end

  // Scan mode shifts SI toward the last flop; functional capture is D = ~Q.
  always @(posedge clk) begin
    if (!primed) begin
      chain  <= chainSeed;
      primed <= 1'b1;
    end else if (enLat) begin
      chain <= sif.se ? {chain[L-2:0], sif.si} : ~chain;
    end
  end

  assign sif.so = chain[L-1];

  int checks = 0;
  int errors = 0;

  logic [L-1:0] patQ[$];
  logic [L-1:0] expQ[$];
  int           stallQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clearSession();
    patQ.delete();
    expQ.delete();
    stallQ.delete();
  endtask

  task automatic addPattern(input logic [L-1:0] p, input logic [L-1:0] e, input int stall);
    patQ.push_back(p);
    expQ.push_back(e);
    stallQ.push_back(stall);
  endtask

  // Runs one session from the queued patterns; extraStartAt re-pulses START at that
  // cycle, abortAt pulls reset at that cycle (0 disables either).
  task automatic applyStimulus(input string name, input int extraStartAt, input int abortAt);
    int           nPat;
    int           misses;
    int           stallSum;
    int           expCycles;
    int           cycles;
    int           idx;
    int           stallLeft;
    bit           finished;
    bit           snapValid;
    logic [L-1:0] snap;
    nPat     = patQ.size();
    misses   = 0;
    stallSum = 0;
    foreach (patQ[i]) begin
      if (expQ[i] !== ~patQ[i]) misses++;
      stallSum += stallQ[i];
    end
    expCycles = 2 + nPat * (L + 2) + L + stallSum;
    $display("[TB] session %s: %0d patterns, %0d bad, %0d stall cycles", name, nPat, misses, stallSum);

    @(negedge clk);
    sif.start     = 1'b1;
    sif.pat_valid = 1'b0;
    cycles        = 1;
    idx           = 0;
    stallLeft     = stallQ[0];
    finished      = 1'b0;
    snapValid     = 1'b0;
    snap          = '0;

    while (!finished && cycles < expCycles + 20) begin
      @(negedge clk);
      cycles++;
      sif.start = (cycles == extraStartAt);
      if (cycles == abortAt) begin
        checkOutput({name, "_pre_abort_se"}, 32'(sif.se), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput({name, "_abort_outputs"},
                    32'({sif.pat_ready, sif.cken, sif.se, sif.si, sif.busy, sif.done, sif.fail, sif.fail_cnt}),
                    32'd0);
        sif.start     = 1'b0;
        sif.pat_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cycles == 2) checkOutput({name, "_busy"}, 32'(sif.busy), 32'd1);
      if (sif.done) begin
        finished = 1'b1;
      end else begin
        sif.pat_valid = 1'b0;
        if (sif.pat_ready && idx < nPat) begin
          if (stallLeft > 0) begin
            checkOutput({name, "_stall_cken"}, 32'(sif.cken), 32'd0);
            if (snapValid) checkOutput({name, "_stall_chain"}, 32'(chain), 32'(snap));
            snap      = chain;
            snapValid = 1'b1;
            stallLeft--;
          end else begin
            sif.pat_data  = patQ[idx];
            sif.exp_data  = expQ[idx];
            sif.pat_last  = (idx == nPat - 1);
            sif.pat_valid = 1'b1;
            idx++;
            stallLeft = (idx < nPat) ? stallQ[idx] : 0;
            snapValid = 1'b0;
          end
        end
      end
    end

    checkOutput({name, "_done_seen"}, 32'(finished), 32'd1);
    if (finished) begin
      checkOutput({name, "_cycles"}, 32'(cycles), 32'(expCycles));
      checkOutput({name, "_busy_end"}, 32'(sif.busy), 32'd0);
      checkOutput({name, "_fail"}, 32'(sif.fail), 32'(misses > 0));
      checkOutput({name, "_fail_cnt"}, 32'(sif.fail_cnt), 32'((misses > 255) ? 255 : misses));
      @(negedge clk);
      checkOutput({name, "_done_pulse"}, 32'(sif.done), 32'd0);
    end
    sif.pat_valid = 1'b0;
  endtask

  initial begin
    logic [L-1:0] p;
    logic [L-1:0] e;
    int           nRand;

    chainSeed     = 8'($urandom);
    sif.start     = 1'b0;
    sif.pat_valid = 1'b0;
    sif.pat_data  = '0;
    sif.exp_data  = '0;
    sif.pat_last  = 1'b0;

    // Reset state of every output
    #12;
    checkOutput("reset_outputs",
                32'({sif.pat_ready, sif.cken, sif.se, sif.si, sif.busy, sif.done, sif.fail, sif.fail_cnt}),
                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single passing pattern
    clearSession();
    addPattern(8'hA5, 8'h5A, 0);
    applyStimulus("one_pat", 0, 0);

    // Three patterns, middle one expects the wrong response
    clearSession();
    addPattern(8'h00, 8'hFF, 0);
    addPattern(8'hFF, 8'h01, 0);
    addPattern(8'h3C, 8'hC3, 0);
    applyStimulus("three_pat", 0, 0);

    // Same run with PAT_VALID withheld for 5 cycles before the second pattern
    clearSession();
    addPattern(8'h00, 8'hFF, 0);
    addPattern(8'hFF, 8'h01, 5);
    addPattern(8'h3C, 8'hC3, 0);
    applyStimulus("stall", 0, 0);

    // Reset during the shift of pattern 2, then a clean session
    clearSession();
    addPattern(8'h5A, 8'hA5, 0);
    addPattern(8'h81, 8'h7E, 0);
    addPattern(8'h0F, 8'hF0, 0);
    applyStimulus("abort", 0, 16);
    clearSession();
    addPattern(8'hA5, 8'h5A, 0);
    addPattern(8'h96, 8'h69, 0);
    applyStimulus("after_abort", 0, 0);

    // START re-pulsed mid-session must not restart it
    clearSession();
    addPattern(8'h00, 8'hFF, 0);
    addPattern(8'hFF, 8'h01, 0);
    addPattern(8'h3C, 8'hC3, 0);
    applyStimulus("restart_ignored", 10, 0);

    // Randomized sessions
    for (int s = 0; s < 5; s++) begin
      clearSession();
      nRand = $urandom_range(1, 6);
      for (int i = 0; i < nRand; i++) begin
        p = 8'($urandom);
        e = ~p;
        if ($urandom_range(0, 2) == 0) e = e ^ 8'($urandom_range(1, 255));
        addPattern(p, e, $urandom_range(0, 3));
      end
      applyStimulus($sformatf("rand%0d", s), 0, 0);
    end

    // Saturation of the failing-pattern counter
    clearSession();
    for (int i = 0; i < 300; i++) begin
      p = 8'($urandom);
      e = ~p ^ (8'd1 << $urandom_range(0, 7));
      addPattern(p, e, 0);
    end
    applyStimulus("saturate", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
